// File: rtl/cache_controller.sv
// Data-cache sequencer between the MEM stage and the SRAM controller.
// Read hits finish in the request cycle; misses fill a line; writes go through without allocate.
module cache_controller #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic [31:0]      address,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             ready,
    output logic             sram_r_en,
    output logic             sram_w_en,
    output logic [31:0]      sram_address,
    output logic [31:0]      sram_wdata,
    input  logic [63:0]      sram_rdata,
    input  logic             sram_ready,
    output logic [16:0]      cache_address,
    output logic [63:0]      cache_write_data,
    output logic             cache_read_en,
    output logic             cache_write_en,
    output logic             cache_invalidate,
    input  logic [31:0]      cache_read_data,
    input  logic             cache_hit,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        WRITE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] offset;
    logic        col;
    logic        hit_inc;
    logic        miss_inc;

    assign offset           = address - BASE_ADDR;
    assign col              = offset[2];
    assign cache_address    = offset[18:2];
    assign sram_address     = address;
    assign sram_wdata       = wdata;
    assign cache_write_data = sram_rdata;

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_next       = state;
        ready            = 1'b0;
        rdata            = '0;
        sram_r_en        = 1'b0;
        sram_w_en        = 1'b0;
        cache_read_en    = 1'b0;
        cache_write_en   = 1'b0;
        cache_invalidate = 1'b0;
        hit_inc          = 1'b0;
        miss_inc         = 1'b0;
        // Gating on rst drops the strobes immediately, before the async reset settles the state.
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (mem_w_en) begin
                        cache_invalidate = 1'b1;
                        state_next       = WRITE;
                    end else if (mem_r_en) begin
                        if (cache_hit) begin
                            cache_read_en = 1'b1;
                            rdata         = cache_read_data;
                            ready         = 1'b1;
                            hit_inc       = 1'b1;
                        end else begin
                            miss_inc   = 1'b1;
                            state_next = MISS;
                        end
                    end else begin
                        ready = 1'b1;
                    end
                end
                MISS: begin
                    sram_r_en = 1'b1;
                    if (sram_ready) begin
                        cache_write_en = 1'b1;
                        ready          = 1'b1;
                        rdata          = col ? sram_rdata[63:32] : sram_rdata[31:0];
                        state_next     = IDLE;
                    end
                end
                WRITE: begin
                    sram_w_en = 1'b1;
                    if (sram_ready) begin
                        ready      = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc && (hit_count != {CNT_W{1'b1}})) begin
                hit_count <= hit_count + 1'b1;
            end
            if (miss_inc && (miss_count != {CNT_W{1'b1}})) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
Sequences the 2-way, 64-set data cache between the MEM stage and the SRAM controller. Read hits complete in the request cycle. Read misses fetch a 64-bit line from SRAM, fill the cache and forward the requested word. Writes are write-through with no allocate: the line is invalidated in the cache and the word is written to SRAM, while the pipeline is frozen via ready.

Parameters:
BASE_ADDR, 32'd1024, byte address mapped to cache/SRAM word 0
CNT_W, 16, width of the saturating hit/miss counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
mem_r_en  in  1  MEM-stage load request
mem_w_en  in  1  MEM-stage store request
address  in  32  byte address
wdata  in  32  store data
rdata  out  32  load data, valid when ready=1 and mem_r_en=1
ready  out  1  0 = freeze pipeline
sram_r_en  out  1  SRAM line read strobe
sram_w_en  out  1  SRAM word write strobe
sram_address  out  32  passes address through
sram_wdata  out  32  passes wdata through
sram_rdata  in  64  fetched line, {word1, word0}
sram_ready  in  1  SRAM op complete, 1-cycle pulse
cache_address  out  17  {tag[9:0], row[5:0], col}
cache_write_data  out  64  equals sram_rdata
cache_read_en  out  1  LRU update strobe
cache_write_en  out  1  line fill strobe
cache_invalidate  out  1  invalidate strobe
cache_read_data  in  32  cache word
cache_hit  in  1  cache hit
hit_count  out  CNT_W  read hits, saturating
miss_count  out  CNT_W  read misses, saturating

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, hit_count=0, miss_count=0. All strobes are 0 as soon as rst is asserted.
- Address mapping: off = address - BASE_ADDR (32-bit wrap); cache_address = off[18:2]. Word select col = off[2].
- State machine, 3 states:
  - IDLE:
    - mem_w_en=1 (wins over mem_r_en): cache_invalidate=1 this cycle only; ready=0; go WRITE.
    - mem_r_en=1 and cache_hit=1: cache_read_en=1; rdata=cache_read_data; ready=1; hit_count+1; stay IDLE.
    - mem_r_en=1 and cache_hit=0: ready=0; miss_count+1; go MISS.
    - No request: ready=1; rdata=0.
  - MISS:
    - sram_r_en=1 and ready=0 until sram_ready.
    - On the sram_ready cycle: cache_write_en=1; ready=1; rdata = col ? sram_rdata[63:32] : sram_rdata[31:0]; go IDLE.
  - WRITE:
    - sram_w_en=1 and ready=0 until sram_ready.
    - On the sram_ready cycle: ready=1; go IDLE.
- Latency:
  - Read hit: 0 extra cycles.
  - Read miss: 1 + SRAM latency; the word is forwarded in the fill cycle, with no cache re-read.
  - Write: 1 + SRAM latency.
- Strobe rules:
  - cache_read_en, cache_write_en and cache_invalidate are mutually exclusive.
  - cache_read_en and cache_invalidate are only asserted in IDLE.
  - sram_r_en and sram_w_en are never asserted together.
- sram_ready arriving in IDLE is ignored.
- Request dropped mid-transaction: the SRAM op still completes, then the FSM returns to IDLE. The request is frozen by ready=0, so this only happens on a flush.
- Back-to-back requests: the request held after a miss completes is re-evaluated in IDLE on the next cycle. With a frozen pipeline the next instruction's request appears then.
- Counters: saturate at 2^CNT_W-1 with no wrap. A hit and a miss cannot both be counted in one cycle.
- Reset mid-MISS/WRITE: return to IDLE immediately, drop the strobes, no fill. Counters clear.
- Outputs are combinational from state and inputs; only state and the counters are registered.

Test Plan:
- Reset mid-fill: rst pulses mid-MISS -> sram_r_en=0 immediately; state IDLE; counters 0; no cache_write_en.
- Cold read miss: mem_r_en, address=0x404, cache_hit=0, sram_ready 4 cycles later with sram_rdata=0xAAAA_BBBB_1111_2222:
  - cache_address=17'h0001 (col=1).
  - ready=0 for 4 cycles, then 1.
  - rdata=0xAAAA_BBBB; cache_write_en=1 in that cycle; miss_count=1.
- Read hit: address=0x400, cache_hit=1, cache_read_data=0x1234 -> ready=1 same cycle; rdata=0x1234; cache_read_en=1; hit_count=1; no SRAM strobes.
- Write-through: mem_w_en, address=0x408, wdata=0xDEAD, sram_ready after 3 cycles:
  - cache_invalidate=1 for exactly 1 cycle.
  - sram_w_en=1 for 3 cycles; sram_wdata=0xDEAD.
  - ready pulses 1 on the completion cycle.
- Simultaneous and stray inputs: mem_r_en=mem_w_en=1 -> write path taken; stray sram_ready in IDLE -> no state change.
- Saturation: CNT_W=2, 5 read hits -> hit_count stays 3.
